// File: rtl/ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_frame_sequencer
//  Description : Walks the pixel/byte indices of one WS2812 frame. For each
//                byte it fetches from the colour source, offers the byte to
//                the output shifter, and after the last byte holds the line
//                idle for the latch gap before pulsing frame_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_frame_sequencer #(
    parameter int LED_COUNT     = 60,
    parameter int BYTES_PER_LED = 3,
    parameter int LATCH_CYCLES  = 1200,
    localparam int IDX_W        = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_req,
    output logic             byte_fetch,
    output logic [IDX_W-1:0] pixel_index,
    output logic [1:0]       byte_index,
    input  logic [7:0]       byte_in,
    output logic [7:0]       shifter_data,
    output logic             shifter_valid,
    input  logic             shifter_req,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             underrun
);

    // The latch counter only needs to hold LATCH_CYCLES-1.
    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_PIXEL = IDX_W'(LED_COUNT - 1);
    localparam logic [1:0]       LAST_BYTE  = 2'(BYTES_PER_LED - 1);
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_STREAM = 3'd3,
        S_LATCH  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pending;
    logic             pending_nxt;
    logic [CNT_W-1:0] latch_cnt;
    logic [CNT_W-1:0] latch_cnt_nxt;

    logic             byte_fetch_nxt;
    logic [IDX_W-1:0] pixel_index_nxt;
    logic [1:0]       byte_index_nxt;
    logic [7:0]       shifter_data_nxt;
    logic             shifter_valid_nxt;
    logic             frame_busy_nxt;
    logic             frame_done_nxt;
    logic             underrun_nxt;

    logic             last_byte;

    assign last_byte = (pixel_index == LAST_PIXEL) && (byte_index == LAST_BYTE);

    // State and every output are registered here; all decisions live in the
    // combinational block below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pending       <= 1'b0;
            latch_cnt     <= '0;
            byte_fetch    <= 1'b0;
            pixel_index   <= '0;
            byte_index    <= '0;
            shifter_data  <= '0;
            shifter_valid <= 1'b0;
            frame_busy    <= 1'b0;
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            latch_cnt     <= latch_cnt_nxt;
            byte_fetch    <= byte_fetch_nxt;
            pixel_index   <= pixel_index_nxt;
            byte_index    <= byte_index_nxt;
            shifter_data  <= shifter_data_nxt;
            shifter_valid <= shifter_valid_nxt;
            frame_busy    <= frame_busy_nxt;
            frame_done    <= frame_done_nxt;
            underrun      <= underrun_nxt;
        end
    end

    // Next-state and next-output logic. byte_fetch is raised on entry to
    // FETCH so that the registered pulse coincides with the FETCH cycle.
    always_comb begin
        state_nxt         = state;
        pending_nxt       = pending;
        latch_cnt_nxt     = latch_cnt;
        byte_fetch_nxt    = 1'b0;
        pixel_index_nxt   = pixel_index;
        byte_index_nxt    = byte_index;
        shifter_data_nxt  = shifter_data;
        shifter_valid_nxt = shifter_valid;
        frame_busy_nxt    = frame_busy;
        frame_done_nxt    = 1'b0;
        underrun_nxt      = underrun;

        // A request arriving mid-frame is remembered (one deep) and served
        // from IDLE right after frame_done.
        if (frame_req && (state != S_IDLE)) begin
            pending_nxt = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (frame_req || pending) begin
                    state_nxt       = S_FETCH;
                    pixel_index_nxt = '0;
                    byte_index_nxt  = '0;
                    frame_busy_nxt  = 1'b1;
                    pending_nxt     = 1'b0;
                    byte_fetch_nxt  = 1'b1;
                end
            end

            S_FETCH: begin
                state_nxt = S_LOAD;
                if (shifter_req) begin
                    underrun_nxt = 1'b1;
                end
            end

            S_LOAD: begin
                state_nxt         = S_STREAM;
                shifter_data_nxt  = byte_in;
                shifter_valid_nxt = 1'b1;
                if (shifter_req) begin
                    underrun_nxt = 1'b1;
                end
            end

            S_STREAM: begin
                if (shifter_req) begin
                    shifter_valid_nxt = 1'b0;
                    if (last_byte) begin
                        state_nxt     = S_LATCH;
                        latch_cnt_nxt = LATCH_LOAD;
                    end else begin
                        state_nxt      = S_FETCH;
                        byte_fetch_nxt = 1'b1;
                        if (byte_index == LAST_BYTE) begin
                            byte_index_nxt  = '0;
                            pixel_index_nxt = pixel_index + IDX_W'(1);
                        end else begin
                            byte_index_nxt = byte_index + 2'd1;
                        end
                    end
                end
            end

            S_LATCH: begin
                if (latch_cnt == '0) begin
                    state_nxt       = S_IDLE;
                    frame_done_nxt  = 1'b1;
                    frame_busy_nxt  = 1'b0;
                    pixel_index_nxt = '0;
                    byte_index_nxt  = '0;
                end else begin
                    latch_cnt_nxt = latch_cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
